// File: rtl/timekeeping_sequencer_pkg.sv
// clock_pkg: state encoding, default moduli and field widths shared with the hand-drive counters
package clock_pkg;
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET   = 2'd1,
    ALIGN = 2'd2
  } state_t;
  localparam int DEF_TICKS_PER_SEC = 100_000_000;
  localparam int DEF_SEC_PER_MIN   = 60;
  localparam int DEF_MIN_PER_HOUR  = 60;
  localparam int DEF_HOURS         = 12;
  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 4;
endpackage

// File: rtl/timekeeping_sequencer_mod_n_counter.sv
// mod_n_counter: modulo-N up counter with sync clear, load-zero and same-edge carry out
module mod_n_counter #(
  parameter int N = 60,
  parameter int W = 6
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  input  logic         zero,
  output logic [W-1:0] count,
  output logic         carry
);
  assign carry = en & (count == W'(N - 1));
  // load-zero beats enable so a held block stays parked at 0
  always_ff @(posedge clock)
    if (reset || zero) count <= '0;
    else if (en) count <= carry ? '0 : count + W'(1);
endmodule

// File: rtl/timekeeping_sequencer.sv
// timekeeping_sequencer: 1 Hz prescaler, seconds/minutes/hours cascade and RUN/SET/ALIGN sequencing
module timekeeping_sequencer
  import clock_pkg::*;
#(
  parameter int TICKS_PER_SEC = DEF_TICKS_PER_SEC,
  parameter int SEC_PER_MIN   = DEF_SEC_PER_MIN,
  parameter int MIN_PER_HOUR  = DEF_MIN_PER_HOUR,
  parameter int HOURS         = DEF_HOURS
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              setMode,
  input  logic              incMinute,
  input  logic              incHour,
  output logic              secondTick,
  output logic              minuteTick,
  output logic              hourTick,
  output logic [SEC_W-1:0]  seconds,
  output logic [MIN_W-1:0]  minutes,
  output logic [HOUR_W-1:0] hours,
  output logic [1:0]        state
);
  localparam int PS_W = $clog2(TICKS_PER_SEC);
  state_t          st;
  logic            run_go;
  logic            in_set;
  logic            ps_carry;
  logic            sec_carry;
  logic            min_carry;
  logic            unused_hr_carry;
  logic [PS_W-1:0] unused_prescaler;
  // a setMode request wins over a terminal prescaler count, so counting only happens when staying in RUN
  assign run_go = (st == RUN) && !setMode;
  assign in_set = st == SET;
  assign state  = st;
  mod_n_counter #(.N(TICKS_PER_SEC), .W(PS_W)) u_prescaler (
    .clock(clock), .reset(reset), .en(run_go), .zero(!run_go),
    .count(unused_prescaler), .carry(ps_carry)
  );
  mod_n_counter #(.N(SEC_PER_MIN), .W(SEC_W)) u_seconds (
    .clock(clock), .reset(reset), .en(ps_carry), .zero(!run_go),
    .count(seconds), .carry(sec_carry)
  );
  mod_n_counter #(.N(MIN_PER_HOUR), .W(MIN_W)) u_minutes (
    .clock(clock), .reset(reset), .en(sec_carry | (in_set & incMinute)), .zero(1'b0),
    .count(minutes), .carry(min_carry)
  );
  // sec_carry is only ever set in RUN, so a manual minute wrap in SET never reaches the hours
  mod_n_counter #(.N(HOURS), .W(HOUR_W)) u_hours (
    .clock(clock), .reset(reset), .en((sec_carry & min_carry) | (in_set & incHour)), .zero(1'b0),
    .count(hours), .carry(unused_hr_carry)
  );
  // mode sequencing plus strobes registered on the same edge the counters move
  always_ff @(posedge clock)
    if (reset) begin
      st         <= RUN;
      secondTick <= 1'b0;
      minuteTick <= 1'b0;
      hourTick   <= 1'b0;
    end else begin
      st         <= st == RUN ? (setMode ? SET : RUN) : st == SET ? (setMode ? SET : ALIGN) : RUN;
      secondTick <= ps_carry;
      minuteTick <= sec_carry;
      hourTick   <= sec_carry & min_carry;
    end
endmodule

// File: tb/tb_timekeeping_sequencer.sv
// tb_timekeeping_sequencer: directed scoreboard bench for the time chain with a 4-cycle second
module tb_timekeeping_sequencer;
  import clock_pkg::*;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       setMode = 1'b0;
  logic       incMinute = 1'b0;
  logic       incHour = 1'b0;
  logic       secondTick;
  logic       minuteTick;
  logic       hourTick;
  logic [5:0] seconds;
  logic [5:0] minutes;
  logic [3:0] hours;
  logic [1:0] state;
  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];
  int passed = 0;
  int failed = 0;
  int total = 0;
  int n;
  timekeeping_sequencer #(.TICKS_PER_SEC(4)) dut (
    .clock(clock), .reset(reset), .setMode(setMode), .incMinute(incMinute), .incHour(incHour),
    .secondTick(secondTick), .minuteTick(minuteTick), .hourTick(hourTick),
    .seconds(seconds), .minutes(minutes), .hours(hours), .state(state)
  );
  // free-running clock
  always #5 clock = ~clock;
  // hard stop in case the sequence itself stalls
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, required summary before 100000 ns");
    $fatal(1, "watchdog expired");
  end
  function automatic logic [31:0] snap(logic [1:0] s, logic [3:0] h, logic [5:0] m, logic [5:0] sec, logic [2:0] t);
    return {11'd0, s, h, m, sec, t};
  endfunction
  function automatic logic [31:0] now();
    return snap(state, hours, minutes, seconds, {secondTick, minuteTick, hourTick});
  endfunction
  task automatic step(int k);
    repeat (k) @(posedge clock);
    #1;
  endtask
  task automatic want(string tag, logic [31:0] v);
    sb.push_back('{tag, v});
  endtask
  task automatic got(logic [31:0] v);
    exp_t e;
    e = sb.pop_front();
    total++;
    assert (v === e.val) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h required %h", e.tag, v, e.val);
    end
  endtask
  task automatic pulse(logic m, logic h);
    incMinute = m;
    incHour = h;
    step(1);
    incMinute = 1'b0;
    incHour = 1'b0;
  endtask
  // directed sequence; snapshot = {state, hours, minutes, seconds, {sec,min,hour}Tick}
  initial begin
    step(2);
    reset = 1'b0;
    want("mid_count", snap(RUN, 0, 0, 17, 3'b000));
    step(70);
    got(now());
    reset = 1'b1;
    want("reset", snap(RUN, 0, 0, 0, 3'b000));
    step(2);
    got(now());
    reset = 1'b0;
    for (int i = 1; i <= 13; i++) begin
      want($sformatf("free_run_%0d", i), snap(RUN, 0, 0, 6'(i / 4), (i % 4 == 0) ? 3'b100 : 3'b000));
      step(1);
      got(now());
    end
    setMode = 1'b1;
    want("enter_set", snap(SET, 0, 0, 0, 3'b000));
    step(1);
    got(now());
    want("set_1159", snap(SET, 11, 59, 0, 3'b000));
    repeat (11) pulse(1'b0, 1'b1);
    repeat (59) pulse(1'b1, 1'b0);
    got(now());
    setMode = 1'b0;
    want("align", snap(ALIGN, 11, 59, 0, 3'b000));
    step(1);
    got(now());
    want("align_exit", snap(RUN, 11, 59, 0, 3'b000));
    step(1);
    got(now());
    for (int s = 1; s <= 60; s++) begin
      step(3);
      if (s == 60) begin
        want("pre_rollover", snap(RUN, 11, 59, 59, 3'b000));
        got(now());
      end
      want($sformatf("sec_%0d", s), s < 60 ? snap(RUN, 11, 59, 6'(s), 3'b100) : snap(RUN, 0, 0, 0, 3'b111));
      step(1);
      got(now());
    end
    setMode = 1'b1;
    step(1);
    want("min58", snap(SET, 0, 58, 0, 3'b000));
    repeat (58) pulse(1'b1, 1'b0);
    got(now());
    for (int k = 0; k < 3; k++) begin
      want($sformatf("min_wrap_%0d", k), snap(SET, 0, 6'((59 + k) % 60), 0, 3'b000));
      pulse(1'b1, 1'b0);
      got(now());
    end
    want("at_0510", snap(SET, 5, 10, 0, 3'b000));
    repeat (9) pulse(1'b1, 1'b0);
    repeat (5) pulse(1'b0, 1'b1);
    got(now());
    want("both_inc", snap(SET, 6, 11, 0, 3'b000));
    pulse(1'b1, 1'b1);
    got(now());
    setMode = 1'b0;
    step(2);
    want("run_inc_ignored", snap(RUN, 6, 11, 0, 3'b000));
    pulse(1'b1, 1'b0);
    got(now());
    want("pre_set", snap(RUN, 6, 11, 2, 3'b000));
    step(10);
    got(now());
    setMode = 1'b1;
    want("set_on_terminal", snap(SET, 6, 11, 0, 3'b000));
    step(1);
    got(now());
    setMode = 1'b0;
    want("align_state", snap(ALIGN, 6, 11, 0, 3'b000));
    step(1);
    got(now());
    incMinute = 1'b1;
    setMode = 1'b1;
    want("align_ignores_inputs", snap(RUN, 6, 11, 0, 3'b000));
    step(1);
    incMinute = 1'b0;
    setMode = 1'b0;
    got(now());
    n = 2;
    want("first_tick_edge", 32'(1 + 4 + 1));
    while (secondTick !== 1'b1 && n < 20) begin
      step(1);
      n++;
    end
    got(32'(n));
    want("after_first_tick", snap(RUN, 6, 11, 1, 3'b100));
    got(now());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
